// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Subtract support is enabled by defining SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } serial_adder_state_t;

  localparam int unsigned MIN_WIDTH = 2;

  // Bit counter only has to reach WIDTH-1.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w < MIN_WIDTH) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand and result handshakes of serial_adder; master drives operands, slave is the adder.
// The in_sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
`ifdef SERIAL_ADDER_SUB_EN
  logic             in_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );
`else
  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_carry
  );
  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_carry
  );
`endif

endinterface

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder; the only arithmetic gate in the serial adder.
module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic p;

  assign p      = a_i ^ b_i;
  assign s_o    = p ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, WIDTH shift cycles per result.
// Define SERIAL_ADDER_SUB_EN to add the in_sub (A-B) mode.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned     CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  serial_adder_state_t state_q, state_d;

  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             carry_q, carry_d;
  logic             cout_q,  cout_d;

  logic acc, shift_en, sub;
  logic fa_s, fa_c;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub = bus.in_sub;
`else
  assign sub = 1'b0;
`endif

  serial_fa_cell u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)   state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST)  state_d = DONE;
      DONE:    if (bus.out_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // in_ready is masked by reset because state_q already reads IDLE while rst_n is low.
  always_comb begin
    bus.in_ready  = rst_n & (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    shift_en      = (state_q == SHIFT);
    acc           = (state_q == IDLE) & bus.in_valid;
  end

  // Carry-out has its own flop so arming carry_q at acceptance never disturbs out_carry.
  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (acc) begin
      a_d     = bus.in_a;
      b_d     = sub ? ~bus.in_b : bus.in_b;
      carry_d = sub;
      cnt_d   = '0;
    end else if (shift_en) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      sum_d   = {fa_s, sum_q[WIDTH-1:1]};
      carry_d = fa_c;
      cout_d  = fa_c;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.out_sum   = sum_q;
  assign bus.out_carry = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus a result scoreboard.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  logic tb_sub;

  int n_tests;
  int n_fail;

  logic [W:0] sb_q[$];
  logic [W:0] exp_v;

  serial_adder_if #(.WIDTH(W)) bus ();

`ifdef SERIAL_ADDER_SUB_EN
  assign bus.in_sub = tb_sub;
`endif

  serial_adder #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Scoreboard: push on operand handshake, pop on result handshake.
  always @(negedge clk) begin
    if (rst_n && bus.in_valid && bus.in_ready)
      sb_q.push_back(model(bus.in_a, bus.in_b, tb_sub));
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
      else begin
        exp_v = sb_q.pop_front();
        chk("sb_sum",   64'(bus.out_sum),   64'(exp_v[W-1:0]));
        chk("sb_carry", 64'(bus.out_carry), 64'(exp_v[W]));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input bit toggle, output int lat);
    int n;
    @(posedge clk); #1;
    bus.in_a     = a;
    bus.in_b     = b;
    tb_sub       = sub;
    bus.in_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 50);
    chk("accept", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1;
    bus.in_valid = toggle;
    if (toggle) begin
      bus.in_a = W'($urandom);
      bus.in_b = W'($urandom);
    end
    lat = 0;
    while (lat < 4 * W) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (toggle) begin
        bus.in_valid = ~bus.in_valid;
        bus.in_a     = W'($urandom);
        bus.in_b     = W'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    chk("done_seen", 64'(bus.out_valid), 64'(1));
  endtask

  logic [W-1:0] pa[3];
  logic [W-1:0] pb[3];

  initial begin
    int lat, idx, cyc, last;
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    tb_sub        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_sum",   64'(bus.out_sum),   64'(0));
    chk("rst_out_carry", 64'(bus.out_carry), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Basic add with latency check
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, lat);
    chk("lat_5a_33",   64'(lat),           64'(W + 1));
    chk("sum_5a_33",   64'(bus.out_sum),   64'(8'h8D));
    chk("carry_5a_33", 64'(bus.out_carry), 64'(0));

    // Back-pressure in DONE, with ignored operands
    @(posedge clk); #1 bus.out_ready = 1'b0;
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
    chk("sum_ff_01",   64'(bus.out_sum),   64'(8'h00));
    chk("carry_ff_01", 64'(bus.out_carry), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_a     = W'($urandom);
      bus.in_b     = W'($urandom);
      @(negedge clk);
      chk("bp_valid",    64'(bus.out_valid), 64'(1));
      chk("bp_sum",      64'(bus.out_sum),   64'(8'h00));
      chk("bp_carry",    64'(bus.out_carry), 64'(1));
      chk("bp_in_ready", 64'(bus.in_ready),  64'(0));
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready",  64'(bus.in_ready),  64'(1));
    chk("bp_release_out_valid", 64'(bus.out_valid), 64'(0));

    // Operand noise during SHIFT/DONE must not disturb the result
    run_op(8'hFF, 8'hFF, 1'b0, 1'b1, lat);
    chk("lat_ff_ff",   64'(lat),           64'(W + 1));
    chk("sum_ff_ff",   64'(bus.out_sum),   64'(8'hFE));
    chk("carry_ff_ff", 64'(bus.out_carry), 64'(1));

    // Reset during SHIFT cycle 4
    @(posedge clk); #1;
    bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_valid = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.in_ready && cyc < 50);
    chk("mid_accept", 64'(bus.in_ready), 64'(1));
    @(posedge clk); #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_in_ready",  64'(bus.in_ready),  64'(0));
    chk("mid_rst_out_sum",   64'(bus.out_sum),   64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(8'h01, 8'h01, 1'b0, 1'b0, lat);
    chk("sum_01_01",   64'(bus.out_sum),   64'(8'h02));
    chk("carry_01_01", 64'(bus.out_carry), 64'(0));

    // Back-to-back with in_valid held high
    pa[0] = 8'hA5; pb[0] = 8'h5B;
    pa[1] = 8'h80; pb[1] = 8'h80;
    pa[2] = 8'h7F; pb[2] = 8'h00;
    @(posedge clk); #1;
    bus.in_a = pa[0]; bus.in_b = pb[0]; bus.in_valid = 1'b1;
    idx = 0; cyc = 0; last = 0;
    while (idx < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.in_ready) begin
        if (idx > 0) chk("b2b_interval", 64'(cyc - last), 64'(W + 2));
        last = cyc;
        idx++;
        @(posedge clk); #1;
        if (idx < 3) begin bus.in_a = pa[idx]; bus.in_b = pb[idx]; end
        else bus.in_valid = 1'b0;
      end
    end
    chk("b2b_accepts", 64'(idx), 64'(3));
    cyc = 0;
    while (sb_q.size() != 0 && cyc < 40) begin @(negedge clk); cyc++; end
    chk("b2b_drain", 64'(sb_q.size()), 64'(0));

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b1, 1'b0, lat);
    chk("sub_10_01",       64'(bus.out_sum),   64'(8'h0F));
    chk("sub_10_01_carry", 64'(bus.out_carry), 64'(1));
    run_op(8'h01, 8'h02, 1'b1, 1'b0, lat);
    chk("sub_01_02",       64'(bus.out_sum),   64'(8'hFF));
    chk("sub_01_02_carry", 64'(bus.out_carry), 64'(0));
    run_op(8'h40, 8'h40, 1'b0, 1'b0, lat);
    chk("add_after_sub",   64'(bus.out_sum),   64'(8'h80));
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty_end", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
